// File: rtl/msix_irq_resp_pkg.sv
// Shared constants and types for the MSI-X doorbell responder: register
// offsets from the doorbell base, AXI response codes and the 64-bit bitmap type.
package msix_irq_resp_pkg;

    localparam logic [20:0] DOORBELL_OFS = 21'h00;
    localparam logic [20:0] PBA_OFS      = 21'h08;
    localparam logic [20:0] MASK_OFS     = 21'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Full-width vector bitmap as seen on the 64-bit data bus.
    typedef logic [63:0] msix_vec_t;

endpackage

// File: rtl/ofs_fim_axi_lite_if.sv
// AXI4-lite bundle (21-bit address, 64-bit data) with slave and master views.
interface ofs_fim_axi_lite_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 64
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/msix_rr_arbiter.sv
// Round-robin picker over the eligible vector bitmap; the search starts one
// past the last vector loaded into the request register.
module msix_rr_arbiter #(
    parameter int NUM_VECTORS = 8,
    parameter int VEC_W       = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_VECTORS-1:0] eligible,
    input  logic                   advance,
    output logic [VEC_W-1:0]       grant,
    output logic                   any
);
    logic [VEC_W-1:0] ptr_q, ptr_d;
    logic [VEC_W-1:0] cand;
    int               idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int i = 0; i < NUM_VECTORS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_VECTORS) idx = idx - NUM_VECTORS;
            cand = VEC_W'(idx);
            if (!any && eligible[cand]) begin
                any   = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) ptr_d = (grant == VEC_W'(NUM_VECTORS - 1)) ? '0 : grant + VEC_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/msix_irq_responder.sv
// MSI-X doorbell responder: AXI4-lite writes latch vectors into a pending bitmap
// that is issued round-robin on irq_req_*. Optional mask register: MSIX_IRQ_RESP_MASK_EN.
module msix_irq_responder
    import msix_irq_resp_pkg::*;
#(
    parameter logic [20:0] MSIX_ADDR   = 21'h80010,
    parameter logic [20:0] PBA_ADDR    = MSIX_ADDR + PBA_OFS,
    parameter int          NUM_VECTORS = 8,
    parameter int          VEC_W       = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ofs_fim_axi_lite_if.slave    axi_lite_s_if,
    output logic                 irq_req_valid,
    output logic [VEC_W-1:0]     irq_req_vector,
    input  logic                 irq_req_ready
);
    localparam logic [20:0] DB_ADDR = MSIX_ADDR + DOORBELL_OFS;

    logic                   ready_en_q, ready_en_d;
    logic                   aw_full_q, aw_full_d;
    logic [20:0]            aw_addr_q, aw_addr_d;
    logic                   w_full_q, w_full_d;
    msix_vec_t              w_data_q, w_data_d;
    logic                   w_strb0_q, w_strb0_d;
    logic                   bvalid_q, bvalid_d;
    logic [1:0]             bresp_q, bresp_d;
    logic                   rvalid_q, rvalid_d;
    msix_vec_t              rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;
    logic [NUM_VECTORS-1:0] pending_q, pending_d;
    logic                   irq_valid_q, irq_valid_d;
    logic [VEC_W-1:0]       irq_vec_q, irq_vec_d;
    logic [NUM_VECTORS-1:0] set_bits, clr_bits, hs_bits, eligible;
    logic                   aw_hs, w_hs, ar_hs, commit, arb_any, arb_advance;
    logic [VEC_W-1:0]       arb_grant;
`ifdef MSIX_IRQ_RESP_MASK_EN
    localparam logic [20:0] MASK_ADDR = MSIX_ADDR + MASK_OFS;
    logic [NUM_VECTORS-1:0] mask_q, mask_d;
`endif

    // Every channel transfers on a clock edge where valid && ready; a source
    // holds valid and its payload stable until then, and never withdraws it.
    assign axi_lite_s_if.awready = ready_en_q & ~aw_full_q & ~bvalid_q;
    assign axi_lite_s_if.wready  = ready_en_q & ~w_full_q & ~bvalid_q;
    assign axi_lite_s_if.arready = ready_en_q & ~rvalid_q;
    assign axi_lite_s_if.bvalid  = bvalid_q;
    assign axi_lite_s_if.bresp   = bresp_q;
    assign axi_lite_s_if.rvalid  = rvalid_q;
    assign axi_lite_s_if.rdata   = rdata_q;
    assign axi_lite_s_if.rresp   = rresp_q;
    assign irq_req_valid         = irq_valid_q;
    assign irq_req_vector        = irq_vec_q;

    assign aw_hs  = axi_lite_s_if.awvalid & axi_lite_s_if.awready;
    assign w_hs   = axi_lite_s_if.wvalid & axi_lite_s_if.wready;
    assign ar_hs  = axi_lite_s_if.arvalid & axi_lite_s_if.arready;
    assign commit = aw_full_q & w_full_q;
`ifdef MSIX_IRQ_RESP_MASK_EN
    assign eligible = pending_q & ~mask_q;
`else
    assign eligible = pending_q;
`endif

    always_comb begin
        ready_en_d = 1'b1;
        aw_full_d  = aw_full_q;
        aw_addr_d  = aw_addr_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb0_d  = w_strb0_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        set_bits   = '0;
        clr_bits   = '0;
        hs_bits    = '0;
`ifdef MSIX_IRQ_RESP_MASK_EN
        mask_d     = mask_q;
`endif
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = axi_lite_s_if.awaddr;
        end
        if (w_hs) begin
            w_full_d  = 1'b1;
            w_data_d  = axi_lite_s_if.wdata;
            w_strb0_d = axi_lite_s_if.wstrb[0];
        end
        if (bvalid_q && axi_lite_s_if.bready) bvalid_d = 1'b0;
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (aw_addr_q == DB_ADDR) begin
                if (w_strb0_q && (w_data_q < 64'(NUM_VECTORS))) begin
                    set_bits = NUM_VECTORS'(1) << w_data_q[VEC_W-1:0];
                    bresp_d  = RESP_OKAY;
                end else begin
                    bresp_d  = RESP_SLVERR;
                end
            end else if (aw_addr_q == PBA_ADDR) begin
                clr_bits = w_data_q[NUM_VECTORS-1:0];
                bresp_d  = RESP_OKAY;
`ifdef MSIX_IRQ_RESP_MASK_EN
            end else if (aw_addr_q == MASK_ADDR) begin
                mask_d  = w_data_q[NUM_VECTORS-1:0];
                bresp_d = RESP_OKAY;
`endif
            end else begin
                bresp_d = RESP_DECERR;
            end
        end
        if (irq_valid_q && irq_req_ready) hs_bits = NUM_VECTORS'(1) << irq_vec_q;
        // A doorbell set overrides both the grant clear and a PBA clear.
        pending_d = (pending_q & ~clr_bits & ~hs_bits) | set_bits;
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && axi_lite_s_if.rready) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_OKAY;
            if (axi_lite_s_if.araddr == PBA_ADDR) begin
                rdata_d = 64'(pending_q);
`ifdef MSIX_IRQ_RESP_MASK_EN
            end else if (axi_lite_s_if.araddr == MASK_ADDR) begin
                rdata_d = 64'(mask_q);
`endif
            end else if (axi_lite_s_if.araddr != DB_ADDR) begin
                rresp_d = RESP_DECERR;
            end
        end
    end

    // Once loaded, the request is held until accepted even if its bit is cleared.
    always_comb begin
        irq_valid_d = irq_valid_q;
        irq_vec_d   = irq_vec_q;
        arb_advance = 1'b0;
        if (irq_valid_q) begin
            if (irq_req_ready) irq_valid_d = 1'b0;
        end else if (arb_any) begin
            irq_valid_d = 1'b1;
            irq_vec_d   = arb_grant;
            arb_advance = 1'b1;
        end
    end

    msix_rr_arbiter #(
        .NUM_VECTORS (NUM_VECTORS),
        .VEC_W       (VEC_W)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .eligible (eligible),
        .advance  (arb_advance),
        .grant    (arb_grant),
        .any      (arb_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q  <= 1'b0;
            aw_full_q   <= 1'b0;
            aw_addr_q   <= '0;
            w_full_q    <= 1'b0;
            w_data_q    <= '0;
            w_strb0_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            pending_q   <= '0;
            irq_valid_q <= 1'b0;
            irq_vec_q   <= '0;
        end else begin
            ready_en_q  <= ready_en_d;
            aw_full_q   <= aw_full_d;
            aw_addr_q   <= aw_addr_d;
            w_full_q    <= w_full_d;
            w_data_q    <= w_data_d;
            w_strb0_q   <= w_strb0_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            pending_q   <= pending_d;
            irq_valid_q <= irq_valid_d;
            irq_vec_q   <= irq_vec_d;
        end
    end

`ifdef MSIX_IRQ_RESP_MASK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mask_q <= '0;
        else     mask_q <= mask_d;
    end
`endif
endmodule
